// File: rtl/joystick_pkg.sv
// Shared definitions for the DB9 joystick scanner: scan FSM encoding,
// pad identifiers, FUDLR bit positions and default timing.
package joystick_pkg;

  typedef enum logic [1:0] {
    ST_SETTLE = 2'd0,
    ST_SAMPLE = 2'd1,
    ST_HOLD   = 2'd2
  } scan_state_t;

  typedef enum logic {
    PAD1 = 1'b0,
    PAD2 = 1'b1
  } pad_t;

  // Bit positions inside a pad word {fire2,fire1,up,down,left,right}
  localparam int BIT_FIRE2 = 5;
  localparam int BIT_FIRE1 = 4;
  localparam int BIT_UP    = 3;
  localparam int BIT_DOWN  = 2;
  localparam int BIT_LEFT  = 1;
  localparam int BIT_RIGHT = 0;

  localparam int PAD_W = 6;

  // Active-low word with nothing pressed
  localparam logic [PAD_W-1:0] RELEASED = 6'h3F;

  // 28 MHz clock: 200 Hz slots, 10 us settle after each select change
  localparam int DEF_SLOT_DIV = 140000;
  localparam int DEF_SETTLE   = 280;

endpackage

// File: rtl/pad_debounce.sv
// Two-sample debouncer for one pad: a value is accepted only when two
// consecutive samples of this pad agree, and a change of the accepted
// value raises a single-cycle update pulse.
module pad_debounce
  import joystick_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             sample_en,
  input  logic [PAD_W-1:0] din,
  output logic [PAD_W-1:0] dout,
  output logic             upd
);

  logic [PAD_W-1:0] raw;

  // Raw history, accepted word and change pulse; clr wipes the pad silently
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      raw  <= RELEASED;
      dout <= RELEASED;
      upd  <= 1'b0;
    end else begin
      upd <= 1'b0;
      if (sample_en) begin
        raw <= din;
        if ((din == raw) && (din != dout)) begin
          dout <= din;
          upd  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/db9_pad_scanner.sv
// Time-slices the single DB9 port between two pads through the splitter:
// drives the select pin, waits for the lines to settle, samples the
// synchronised port once per slot and hands the sample to the pad that
// owns the current slot.
module db9_pad_scanner
  import joystick_pkg::*;
#(
  parameter int SLOT_DIV = DEF_SLOT_DIV,
  parameter int SETTLE   = DEF_SETTLE
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       splitter_en,
  input  logic [5:0] db9_in,
  output logic       db9_sel,
  output logic [5:0] joy1_out,
  output logic [5:0] joy2_out,
  output logic       joy1_upd,
  output logic       joy2_upd
);

  localparam int CNT_W = $clog2(SLOT_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(SLOT_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_SETTLE = CNT_W'(SETTLE);

  logic [CNT_W-1:0] slot_cnt;
  logic [CNT_W-1:0] slot_cnt_nxt;
  scan_state_t      state;
  scan_state_t      state_nxt;
  pad_t             cur_pad;
  logic             first_slot;
  logic             split_q;
  logic [PAD_W-1:0] sync1;
  logic [PAD_W-1:0] sync2;
  logic             boundary;
  logic             sample_en;
  logic             split_fall;
  logic             pad1_sample;
  logic             pad2_sample;

  // Slot counter and scan state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_cnt <= '0;
      state    <= ST_SETTLE;
    end else begin
      slot_cnt <= slot_cnt_nxt;
      state    <= state_nxt;
    end
  end

  // Next slot position, scan state derived from it, and per-cycle strobes
  always_comb begin
    boundary     = (slot_cnt == CNT_LAST);
    slot_cnt_nxt = boundary ? '0 : slot_cnt + CNT_W'(1);
    sample_en    = (state == ST_SAMPLE);
    state_nxt    = ST_HOLD;
    if (slot_cnt_nxt < CNT_SETTLE) begin
      state_nxt = ST_SETTLE;
    end else if (slot_cnt_nxt == CNT_SETTLE) begin
      state_nxt = ST_SAMPLE;
    end
  end

  // Steering: pad2 owns a sample only while the splitter is enabled and
  // either the slot was assigned to pad2 at its boundary or this is the
  // first slot after reset, which starts with the select pin high
  always_comb begin
    split_fall  = split_q && !splitter_en;
    pad2_sample = sample_en && splitter_en &&
                  ((cur_pad == PAD2) || first_slot);
    pad1_sample = sample_en && !pad2_sample;
  end

  // Select pin and slot ownership, updated at slot boundaries; a splitter
  // disable immediately hands the rest of the slot to pad1
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      db9_sel    <= 1'b1;
      cur_pad    <= PAD1;
      first_slot <= 1'b1;
      split_q    <= 1'b1;
    end else begin
      split_q <= splitter_en;
      if (boundary) begin
        first_slot <= 1'b0;
        if (splitter_en) begin
          db9_sel <= ~db9_sel;
          cur_pad <= db9_sel ? PAD1 : PAD2;
        end else begin
          db9_sel <= 1'b1;
          cur_pad <= PAD1;
        end
      end else if (split_fall) begin
        first_slot <= 1'b0;
        cur_pad    <= PAD1;
      end
    end
  end

  // Two-flop synchroniser for the asynchronous port pins
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= RELEASED;
      sync2 <= RELEASED;
    end else begin
      sync1 <= db9_in;
      sync2 <= sync1;
    end
  end

  pad_debounce u_pad1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (1'b0),
    .sample_en (pad1_sample),
    .din       (sync2),
    .dout      (joy1_out),
    .upd       (joy1_upd)
  );

  pad_debounce u_pad2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (split_fall),
    .sample_en (pad2_sample),
    .din       (sync2),
    .dout      (joy2_out),
    .upd       (joy2_upd)
  );

endmodule

// File: tb/tb_db9_pad_scanner.sv
// Scoreboard bench for db9_pad_scanner with short slots (16 cycles, settle 4).
// Expected pad updates are queued by the stimulus; the monitor pops one
// entry per update pulse. Bench cycle 'cyc' equals the slot counter value.
module tb_db9_pad_scanner;

  localparam int SLOT_DIV = 16;
  localparam int SETTLE   = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       splitter_en = 1'b0;
  logic [5:0] db9_in = 6'h3F;
  logic       db9_sel;
  logic [5:0] joy1_out;
  logic [5:0] joy2_out;
  logic       joy1_upd;
  logic       joy2_upd;

  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  logic       follow = 1'b0;
  logic [5:0] pad1_val = 6'h3F;
  logic [5:0] pad2_val = 6'h3F;
  logic [5:0] q1[$];
  logic [5:0] q2[$];
  logic [5:0] exp_val;

  db9_pad_scanner #(
    .SLOT_DIV (SLOT_DIV),
    .SETTLE   (SETTLE)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .splitter_en (splitter_en),
    .db9_in      (db9_in),
    .db9_sel     (db9_sel),
    .joy1_out    (joy1_out),
    .joy2_out    (joy2_out),
    .joy1_upd    (joy1_upd),
    .joy2_upd    (joy2_upd)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // Monitor: every update pulse must match the next queued expectation
  always @(negedge clk) begin
    if (joy1_upd) begin
      checks++;
      if (q1.size() == 0) begin
        failures++;
        $display("[TB] FAIL joy1_upd: unexpected pulse with joy1_out=%h, required no update (cycle %0d)", joy1_out, cyc);
      end else begin
        exp_val = q1.pop_front();
        if (joy1_out !== exp_val) begin
          failures++;
          $display("[TB] FAIL joy1_update_value: got %h, required %h (cycle %0d)", joy1_out, exp_val, cyc);
        end
      end
    end
    if (joy2_upd) begin
      checks++;
      if (q2.size() == 0) begin
        failures++;
        $display("[TB] FAIL joy2_upd: unexpected pulse with joy2_out=%h, required no update (cycle %0d)", joy2_out, cyc);
      end else begin
        exp_val = q2.pop_front();
        if (joy2_out !== exp_val) begin
          failures++;
          $display("[TB] FAIL joy2_update_value: got %h, required %h (cycle %0d)", joy2_out, exp_val, cyc);
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [5:0] act, input logic [5:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Advance n cycles; in follow mode the port shows the selected pad
  task automatic applyStimulus(input int n);
    repeat (n) begin
      @(negedge clk);
      cyc++;
      if (follow) db9_in = db9_sel ? pad2_val : pad1_val;
    end
  endtask

  task automatic runTo(input int t);
    while (cyc < t) applyStimulus(1);
  endtask

  task automatic doReset(input int n);
    rst_n = 1'b0;
    applyStimulus(n);
    checkOutput("rst_db9_sel", {5'd0, db9_sel}, 6'h01);
    checkOutput("rst_joy1_out", joy1_out, 6'h3F);
    checkOutput("rst_joy2_out", joy2_out, 6'h3F);
    checkOutput("rst_joy1_upd", {5'd0, joy1_upd}, 6'h00);
    checkOutput("rst_joy2_upd", {5'd0, joy2_upd}, 6'h00);
    rst_n = 1'b1;
    cyc = 0;
  endtask

  initial begin
    // Reset, then single pad holding right pressed
    splitter_en = 1'b0;
    follow = 1'b0;
    db9_in = 6'h3E;
    doReset(2);
    q1.push_back(6'h3E);
    for (int i = 1; i <= 21; i++) begin
      applyStimulus(1);
      checkOutput("single_db9_sel", {5'd0, db9_sel}, 6'h01);
      if (i == 20) checkOutput("single_joy1_before", joy1_out, 6'h3F);
      if (i == 21) begin
        checkOutput("single_joy1_after", joy1_out, 6'h3E);
        checkOutput("single_joy1_upd", {5'd0, joy1_upd}, 6'h01);
      end
    end
    runTo(40);
    checkOutput("single_joy2_idle", joy2_out, 6'h3F);
    checkOutput("single_sel_late", {5'd0, db9_sel}, 6'h01);

    // Release back to idle, then a one-slot glitch that must be ignored
    runTo(48);
    db9_in = 6'h3F;
    q1.push_back(6'h3F);
    runTo(72);
    checkOutput("release_joy1", joy1_out, 6'h3F);
    runTo(80);
    db9_in = 6'h1F;
    runTo(96);
    db9_in = 6'h3F;
    runTo(128);
    checkOutput("glitch_joy1", joy1_out, 6'h3F);

    // Two pads through the splitter, first slot belongs to pad2
    splitter_en = 1'b1;
    pad1_val = 6'h3D;
    pad2_val = 6'h2F;
    follow = 1'b1;
    db9_in = 6'h2F;
    doReset(2);
    q2.push_back(6'h2F);
    q1.push_back(6'h3D);
    runTo(8);
    checkOutput("split_sel_slot0", {5'd0, db9_sel}, 6'h01);
    runTo(24);
    checkOutput("split_sel_slot1", {5'd0, db9_sel}, 6'h00);
    runTo(36);
    checkOutput("split_joy2_before", joy2_out, 6'h3F);
    runTo(37);
    checkOutput("split_joy2_after", joy2_out, 6'h2F);
    checkOutput("split_joy2_upd", {5'd0, joy2_upd}, 6'h01);
    runTo(40);
    checkOutput("split_sel_slot2", {5'd0, db9_sel}, 6'h01);
    runTo(56);
    checkOutput("split_sel_slot3", {5'd0, db9_sel}, 6'h00);
    checkOutput("split_joy1", joy1_out, 6'h3D);
    runTo(64);
    checkOutput("split_joy1_hold", joy1_out, 6'h3D);
    checkOutput("split_joy2_hold", joy2_out, 6'h2F);

    // Splitter disabled mid-HOLD of a pad1 slot
    runTo(88);
    checkOutput("dis_sel_before", {5'd0, db9_sel}, 6'h00);
    splitter_en = 1'b0;
    q1.push_back(6'h2F);
    applyStimulus(1);
    checkOutput("dis_joy2_cleared", joy2_out, 6'h3F);
    checkOutput("dis_joy2_upd", {5'd0, joy2_upd}, 6'h00);
    checkOutput("dis_sel_until_boundary", {5'd0, db9_sel}, 6'h00);
    runTo(96);
    checkOutput("dis_sel_forced", {5'd0, db9_sel}, 6'h01);
    runTo(116);
    checkOutput("dis_joy1_before", joy1_out, 6'h3D);
    runTo(117);
    checkOutput("dis_joy1_to_pad1", joy1_out, 6'h2F);
    checkOutput("dis_joy2_stays", joy2_out, 6'h3F);

    // Reset during SETTLE of a pad2 slot
    splitter_en = 1'b1;
    doReset(2);
    q2.push_back(6'h2F);
    q1.push_back(6'h3D);
    runTo(66);
    checkOutput("midrst_joy2_before", joy2_out, 6'h2F);
    checkOutput("midrst_sel_before", {5'd0, db9_sel}, 6'h01);
    doReset(1);
    runTo(15);
    checkOutput("midrst_sel_slot0", {5'd0, db9_sel}, 6'h01);
    runTo(16);
    checkOutput("midrst_sel_slot1", {5'd0, db9_sel}, 6'h00);

    checks++;
    if ((q1.size() != 0) || (q2.size() != 0)) begin
      failures++;
      $display("[TB] FAIL pending_updates: got q1=%0d q2=%0d outstanding, required 0", q1.size(), q2.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
